// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register bank.
// Holds the SPI frame FSM state encoding and the R/W command bit values.
package spi_regbank_pkg;

    // Frame-level FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_t;

    // First bit of every frame selects the direction
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Bit counter width; covers both the command field (1+ADDR_W <= 8)
    // and the longest data word (32)
    localparam int CNT_W = 6;

endpackage

// File: rtl/spi_regbank_sync.sv
// Two-flop synchronizer for one SPI pin, with rise/fall pulses detected
// on the synchronized value. Edge pulses are held off until the chain has
// been refilled from the real pin after reset, so a level that was already
// away from IDLE_LVL at reset release never looks like an edge.
module spi_regbank_sync #(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] fill_q;
    logic       armed;

    // Synchronizer chain, edge-detect delay stage and post-reset fill counter
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta_q <= IDLE_LVL;
            sync_q <= IDLE_LVL;
            prev_q <= IDLE_LVL;
            fill_q <= 2'd0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's
            // pre-edge value; blocking would collapse the chain into one flop.
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    assign armed    = (fill_q == 2'd3);
    assign sync_out = sync_q;
    assign rise     = armed &  sync_q & ~prev_q;
    assign fall     = armed & ~sync_q &  prev_q;

endmodule

// File: rtl/spi_regbank.sv
// SPI (mode 0) slave register bank: NUM_CFG read/write config registers
// followed by NUM_STS read-only status registers in one address space.
// Frame: R/W bit (1 = write), ADDR_W address bits, WIDTH data bits, MSB
// first. Status inputs are snapshotted when chip select falls so a frame
// reads a coherent set of values.
// Optional feature: define SPI_REGBANK_AUTOINC_EN for burst transfers, where
// the address increments after every data word (wrapping to 0 after the last
// mapped register). Without it the FSM parks in DONE until chip select rises.
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter  int NUM_CFG  = 8,
    parameter  int NUM_STS  = 4,
    parameter  int WIDTH    = 8,
    localparam int NUM_REGS = NUM_CFG + NUM_STS,
    localparam int ADDR_W   = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1,
    localparam int STS_N    = (NUM_STS > 0) ? NUM_STS : 1
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic                            spi_cs_n,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    output logic [NUM_CFG-1:0][WIDTH-1:0]   config_regs,
    output logic [NUM_CFG-1:0]              cfg_wr_strobe,
    input  logic [STS_N-1:0][WIDTH-1:0]     status_regs
);

    // Synchronized pin levels and edge pulses
    logic cs_s,   cs_rise,   cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    // Frame state
    spi_state_t                     state;
    logic [CNT_W-1:0]               bit_cnt;
    logic [ADDR_W-1:0]              cmd_sr;
    logic [WIDTH-1:0]               data_sr;
    logic [ADDR_W-1:0]              addr_q;
    logic                           rw_q;
    logic [WIDTH-1:0]               miso_sr;
    logic [STS_N-1:0][WIDTH-1:0]    shadow;

    // Write commit handshake into the config bank
    logic                           wr_pend;
    logic [ADDR_W-1:0]              wr_addr;

    // Combinational helpers
    logic [ADDR_W:0]                cmd_next;
    logic [WIDTH-1:0]               data_next;
    logic [ADDR_W-1:0]              inc_addr;
    logic [ADDR_W-1:0]              lk_addr;
    logic [WIDTH-1:0]               rd_word;

    spi_regbank_sync #(.IDLE_LVL(1'b1)) u_sync_cs (
        .clk      (clk),
        .rstb     (rstb),
        .async_in (spi_cs_n),
        .sync_out (cs_s),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    spi_regbank_sync #(.IDLE_LVL(1'b0)) u_sync_sclk (
        .clk      (clk),
        .rstb     (rstb),
        .async_in (spi_clk),
        .sync_out (sclk_s),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_regbank_sync #(.IDLE_LVL(1'b0)) u_sync_mosi (
        .clk      (clk),
        .rstb     (rstb),
        .async_in (spi_mosi),
        .sync_out (mosi_s),
        .rise     (mosi_rise),
        .fall     (mosi_fall)
    );

    // Levels of cs/sclk and mosi edges are not needed; only edges and mosi level are
    assign unused_sync = ^{cs_s, sclk_s, mosi_rise, mosi_fall};

    assign cmd_next  = {cmd_sr, mosi_s};
    assign data_next = WIDTH'({data_sr, mosi_s});

    // Read-data lookup: command address while finishing CMD, next burst address otherwise
    always_comb begin
        // NOTE: every output gets a default before any branch, otherwise a
        // path that skips the assignment infers a latch.
        inc_addr = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + ADDR_W'(1);
        lk_addr  = (state == ST_CMD) ? cmd_next[ADDR_W-1:0] : inc_addr;
        rd_word  = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (lk_addr == ADDR_W'(i)) begin
                rd_word = config_regs[i];
            end
        end
        for (int j = 0; j < NUM_STS; j++) begin
            if (lk_addr == ADDR_W'(NUM_CFG + j)) begin
                rd_word = shadow[j];
            end
        end
    end

    // Frame FSM: command/data shifting, MISO shifter, status snapshot, write hand-off
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            cmd_sr  <= '0;
            data_sr <= '0;
            addr_q  <= '0;
            rw_q    <= RW_READ;
            miso_sr <= '0;
            shadow  <= '0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_pend <= 1'b0;
            if (!ena || (cs_rise && (state != ST_IDLE))) begin
                // Disable or chip-select release aborts any partial frame
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                            cmd_sr  <= '0;
                            shadow  <= status_regs;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= cmd_next[ADDR_W-1:0];
                            if (bit_cnt == CNT_W'(ADDR_W)) begin
                                state   <= ST_DATA;
                                bit_cnt <= '0;
                                rw_q    <= cmd_next[ADDR_W];
                                addr_q  <= cmd_next[ADDR_W-1:0];
                                miso_sr <= rd_word;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            data_sr <= data_next;
                            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                                wr_pend <= (rw_q == RW_WRITE);
                                wr_addr <= addr_q;
                                bit_cnt <= '0;
`ifdef SPI_REGBANK_AUTOINC_EN
                                addr_q  <= inc_addr;
                                miso_sr <= rd_word;
`else
                                state   <= ST_DONE;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end else if (sclk_fall && (bit_cnt != '0)) begin
                            // The falling edge right after a load keeps the MSB
                            // on the line for the master's first sample
                            miso_sr <= WIDTH'({miso_sr, 1'b0});
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Config bank: commit a completed write one cycle after its last bit
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            // NOTE: the bank is plain flops, not a RAM, so it is cleared by
            // the async reset like any other state.
            config_regs   <= '0;
            cfg_wr_strobe <= '0;
        end else begin
            cfg_wr_strobe <= '0;
            if (wr_pend && ena) begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (wr_addr == ADDR_W'(i)) begin
                        config_regs[i]   <= data_sr;
                        cfg_wr_strobe[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign spi_miso = ena && (state == ST_DATA) && miso_sr[WIDTH-1];

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank (default parameters). A bit-banged SPI
// master drives frames; a behavioural register map predicts read data,
// write strobes and config contents.
module tb_spi_regbank;

    localparam int NUM_CFG = 8;
    localparam int NUM_STS = 4;
    localparam int WIDTH   = 8;
    localparam int AW      = 4;
    localparam int NREG    = NUM_CFG + NUM_STS;
    localparam int HALF    = 50;

    logic clk      = 1'b0;
    logic rstb     = 1'b0;
    logic ena      = 1'b1;
    logic spi_cs_n = 1'b1;
    logic spi_clk  = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic [NUM_CFG-1:0][WIDTH-1:0] config_regs;
    logic [NUM_CFG-1:0]            cfg_wr_strobe;
    logic [NUM_STS-1:0][WIDTH-1:0] status_regs = '0;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] cfg_m    [NUM_CFG];
    logic [7:0] wr_words [4];
    logic [7:0] strobe_log [$];

    spi_regbank #(.NUM_CFG(NUM_CFG), .NUM_STS(NUM_STS), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .ena           (ena),
        .spi_cs_n      (spi_cs_n),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .config_regs   (config_regs),
        .cfg_wr_strobe (cfg_wr_strobe),
        .status_regs   (status_regs)
    );

    always #5 clk = ~clk;

    // Record every cycle in which any write strobe is high
    always @(negedge clk) begin
        if (cfg_wr_strobe != '0) strobe_log.push_back(cfg_wr_strobe);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cfg_model_vec();
        logic [63:0] v = '0;
        for (int i = 0; i < NUM_CFG; i++) v[i*8 +: 8] = cfg_m[i];
        return v;
    endfunction

    function automatic logic frame_bit(input bit rw, input int addr, input int b);
        int d;
        if (b == 0) return rw;
        if (b < 1 + AW) return addr[AW - b];
        d = b - 1 - AW;
        return wr_words[d / 8][7 - (d % 8)];
    endfunction

    function automatic int next_addr(input int a);
        return (a == NREG - 1) ? 0 : (a + 1) % 16;
    endfunction

    // One SPI frame. stop_bit/rst_bit/ena_bit: bit index at which cs rises,
    // reset pulses, or ena drops (-1 = never).
    task automatic spi_frame(input bit rw, input int addr, input int nwords,
                             input int stop_bit, input int rst_bit, input int ena_bit);
        int nbits, ev, done_words, used_words, a, w;
        bit did_rst, ena_low;
        logic [7:0] snap [NUM_STS];
        logic [7:0] rd_bits [4];
        logic [7:0] exp_strobes [$];
        logic [7:0] nv, exp_rd;

        nbits   = 1 + AW + 8 * nwords;
        did_rst = 1'b0;
        ena_low = 1'b0;
        for (int i = 0; i < 4; i++) rd_bits[i] = '0;
        for (int i = 0; i < NUM_STS; i++) snap[i] = status_regs[i];
        ev = nbits;
        if (stop_bit >= 0 && stop_bit < ev) ev = stop_bit;
        if (rst_bit  >= 0 && rst_bit  < ev) ev = rst_bit;
        if (ena_bit  >= 0 && ena_bit  < ev) ev = ena_bit;
        strobe_log.delete();

        @(negedge clk);
        spi_cs_n = 1'b0;
        #(HALF);
        for (int b = 0; b < nbits && (stop_bit < 0 || b < stop_bit); b++) begin
            if (b == rst_bit) begin
                rstb = 1'b0;
                #10;
                check("rst_config", config_regs, 64'h0);
                check("rst_strobe", cfg_wr_strobe, 64'h0);
                check("rst_miso", spi_miso, 64'h0);
                #20;
                rstb    = 1'b1;
                did_rst = 1'b1;
            end
            if (b == ena_bit) begin
                ena     = 1'b0;
                ena_low = 1'b1;
            end
            if (b == 2) begin
                // Status moves under the frame; reads must still see the snapshot
                for (int i = 0; i < NUM_STS; i++) begin
                    nv = 8'($urandom);
                    if (nv == status_regs[i]) nv = ~nv;
                    status_regs[i] = nv;
                end
            end
            spi_mosi = frame_bit(rw, addr, b);
            #(HALF);
            if (ena_low || did_rst) begin
                check("miso_quiet", spi_miso, 64'h0);
            end else if (b < 1 + AW) begin
                check("miso_cmd", spi_miso, 64'h0);
            end else begin
                w = (b - 1 - AW) / 8;
                rd_bits[w] = {rd_bits[w][6:0], spi_miso};
            end
            spi_clk = 1'b1;
            #(HALF);
            spi_clk = 1'b0;
        end
        #(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #(4 * HALF);
        ena = 1'b1;
        #(4 * HALF);

        // Reference model: apply every data word fully clocked before the abort point
        done_words = (ev >= 1 + AW) ? (ev - 1 - AW) / 8 : 0;
`ifdef SPI_REGBANK_AUTOINC_EN
        used_words = done_words;
`else
        used_words = (done_words > 0) ? 1 : 0;
`endif
        a = addr;
        for (int k = 0; k < done_words; k++) begin
            if (k < used_words) begin
                if (rw) begin
                    if (a < NUM_CFG) begin
                        cfg_m[a] = wr_words[k];
                        exp_strobes.push_back(8'(1 << a));
                    end
                end else begin
                    if (a < NUM_CFG)   exp_rd = cfg_m[a];
                    else if (a < NREG) exp_rd = snap[a - NUM_CFG];
                    else               exp_rd = 8'h00;
                    check($sformatf("read_a%0d", a), rd_bits[k], exp_rd);
                end
            end else if (!rw) begin
                check("read_after_done", rd_bits[k], 64'h0);
            end
            a = next_addr(a);
        end
        if (did_rst) begin
            for (int i = 0; i < NUM_CFG; i++) cfg_m[i] = 8'h00;
        end

        check("strobe_count", strobe_log.size(), exp_strobes.size());
        if (strobe_log.size() == exp_strobes.size()) begin
            foreach (exp_strobes[i]) check("strobe", strobe_log[i], exp_strobes[i]);
        end
        check("config", config_regs, cfg_model_vec());
        check("miso_idle", spi_miso, 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rw, addr, nw, stop;
        for (int i = 0; i < NUM_CFG; i++) cfg_m[i] = 8'h00;

        // Reset state
        #22;
        check("reset_config", config_regs, 64'h0);
        check("reset_strobe", cfg_wr_strobe, 64'h0);
        check("reset_miso", spi_miso, 64'h0);
        #18;
        rstb = 1'b1;
        #100;

        // Single write to cfg[3]
        wr_words[0] = 8'hA5;
        spi_frame(1'b1, 3, 1, -1, -1, -1);

        // Status snapshot: status[1] = 0x3C at cs fall, changed mid-frame
        status_regs[1] = 8'h3C;
        spi_frame(1'b0, 9, 1, -1, -1, -1);

        // Writes to status and unmapped space, read of unmapped
        wr_words[0] = 8'h77;
        spi_frame(1'b1, 10, 1, -1, -1, -1);
        wr_words[0] = 8'h66;
        spi_frame(1'b1, 15, 1, -1, -1, -1);
        spi_frame(1'b0, 15, 1, -1, -1, -1);
        spi_frame(1'b0, 3, 1, -1, -1, -1);

        // cs raised after 5 of 8 data bits, then a full frame
        wr_words[0] = 8'hC7;
        spi_frame(1'b1, 0, 1, 1 + AW + 5, -1, -1);
        spi_frame(1'b1, 0, 1, -1, -1, -1);

        // Bursts: from 7 into status, from 11 wrapping to 0, burst read
        wr_words[0] = 8'h11; wr_words[1] = 8'h22;
        spi_frame(1'b1, 7, 2, -1, -1, -1);
        wr_words[0] = 8'h5A; wr_words[1] = 8'h6B;
        spi_frame(1'b1, 11, 2, -1, -1, -1);
        spi_frame(1'b0, 6, 3, -1, -1, -1);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            rw   = int'($urandom_range(0, 1));
            addr = int'($urandom_range(0, 15));
            nw   = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) wr_words[k] = 8'($urandom);
            for (int i = 0; i < NUM_STS; i++) status_regs[i] = 8'($urandom);
            stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 1 + AW + 8 * nw - 1)) : -1;
            spi_frame(rw[0], addr, nw, stop, -1, -1);
        end

        // Reset mid-write, then ena low mid-write, then a normal frame
        wr_words[0] = 8'h3E;
        spi_frame(1'b1, 2, 1, -1, 1 + AW + 3, -1);
        wr_words[0] = 8'hE3;
        spi_frame(1'b1, 4, 1, -1, -1, 1 + AW + 2);
        spi_frame(1'b1, 4, 1, -1, -1, -1);
        spi_frame(1'b0, 4, 1, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
